// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_e;

  typedef logic [3:0] bcd_t;

  // Rollover value of each digit: tenths, seconds units, seconds tens, minutes
  localparam bcd_t DIG_MAX [4] = '{4'd9, 4'd9, 4'd5, 4'd9};

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command pulses in, BCD time digits and status strobes out.
interface stopwatch_ctrl_if;

  logic                start_i;
  logic                stop_i;
  logic                clear_i;
  stopwatch_pkg::bcd_t dig0_o;
  stopwatch_pkg::bcd_t dig1_o;
  stopwatch_pkg::bcd_t dig2_o;
  stopwatch_pkg::bcd_t dig3_o;
  logic                running_o;
  logic                tick_o;
  logic                wrap_o;

  modport master (
    output start_i, stop_i, clear_i,
    input  dig0_o, dig1_o, dig2_o, dig3_o, running_o, tick_o, wrap_o
  );

  modport slave (
    input  start_i, stop_i, clear_i,
    output dig0_o, dig1_o, dig2_o, dig3_o, running_o, tick_o, wrap_o
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MAX on enable and flags its rollover as a carry.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output bcd_t q_o,
  output logic carry_o
);

  bcd_t q;

  // Clear outranks counting so a clear on a tick edge still lands on zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (clr_i) begin
      q <= '0;
    end else if (en_i) begin
      q <= (q == MAX) ? '0 : q + 4'd1;
    end
  end

  assign q_o     = q;
  assign carry_o = en_i & (q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/idle sequencing, 0.1 s prescaler and the M:SS.T digit chain.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  stopwatch_ctrl_if.slave bus
);

  localparam int              DIV_W     = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

  sw_state_e        state;
  logic [DIV_W-1:0] presc;
  logic             running_q;
  logic             tick;
  logic             carry0, carry1, carry2, carry3;

  // Priority clear > stop > start; the prescaler only advances in an undisturbed RUN cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      presc     <= '0;
      running_q <= 1'b0;
    end else if (bus.clear_i) begin
      state     <= IDLE;
      presc     <= '0;
      running_q <= 1'b0;
    end else if (bus.stop_i) begin
      if (state == RUN) begin
        state     <= PAUSE;
        running_q <= 1'b0;
      end
    end else begin
      if (bus.start_i) begin
        state     <= RUN;
        running_q <= 1'b1;
      end
      if (state == RUN) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + DIV_W'(1);
      end
    end
  end

  assign tick = (state == RUN) & (presc == PRESC_MAX) & ~bus.stop_i & ~bus.clear_i;

  bcd_digit_counter #(.MAX(DIG_MAX[0])) u_dig0 (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i),
    .en_i(tick), .q_o(bus.dig0_o), .carry_o(carry0)
  );

  bcd_digit_counter #(.MAX(DIG_MAX[1])) u_dig1 (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i),
    .en_i(carry0), .q_o(bus.dig1_o), .carry_o(carry1)
  );

  bcd_digit_counter #(.MAX(DIG_MAX[2])) u_dig2 (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i),
    .en_i(carry1), .q_o(bus.dig2_o), .carry_o(carry2)
  );

  // The minutes carry only fires on a tick at 9:59.9, which is exactly the wrap condition
  bcd_digit_counter #(.MAX(DIG_MAX[3])) u_dig3 (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i),
    .en_i(carry2), .q_o(bus.dig3_o), .carry_o(carry3)
  );

  assign bus.running_o = running_q;
  assign bus.tick_o    = tick;
  assign bus.wrap_o    = carry3;

endmodule
